// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types and sizing helpers for the multiplier arbiter
package mult_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int ID_W = 1;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/booth_mult_core.sv
// rtl/booth_mult_core.sv - iterative radix-2 Booth multiplier, one step per cycle
// done is high during the final step; p carries that step's result (the full product).
module booth_mult_core
  import mult_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   x,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = cnt_w(N);

  logic [N:0]    a_ext;
  logic [N:0]    acc;
  logic [N-1:0]  q;
  logic          q_m1;
  logic [CW-1:0] cnt;
  logic          running;
  logic [N:0]    sum;
  logic [N:0]    nxt_acc;
  logic [N-1:0]  nxt_q;

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + a_ext;
      2'b10:   sum = acc - a_ext;
      default: sum = acc;
    endcase
    // Arithmetic right shift of the {acc, q} pair.
    nxt_acc = {sum[N], sum[N:1]};
    nxt_q   = {sum[0], q[N-1:1]};
  end

  assign done = running && (cnt == CW'(N - 1));
  assign p    = {nxt_acc[N-1:0], nxt_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ext   <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      a_ext   <= {a[N-1], a};
      acc     <= '0;
      q       <= x;
      q_m1    <= 1'b0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc  <= nxt_acc;
      q    <= nxt_q;
      q_m1 <= q[0];
      cnt  <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter/sequencer for a shared Booth multiplier
// Define MULT_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_x,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_x,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_p,
  output logic           busy
);

  state_t          state;
  logic [ID_W-1:0] grant_id;
  logic            start;
  logic            core_done;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_x;
  logic [2*N-1:0]  core_p;
`ifdef MULT_ARB_RR_EN
  logic            ptr;
`endif

  // ptr high means requester 1 wins a tie.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
`ifdef MULT_ARB_RR_EN
      if (req0_valid && !(req1_valid && ptr)) req0_ready = 1'b1;
      else if (req1_valid)                    req1_ready = 1'b1;
`else
      if (req0_valid)      req0_ready = 1'b1;
      else if (req1_valid) req1_ready = 1'b1;
`endif
    end
  end

  assign start    = req0_ready | req1_ready;
  assign grant_id = req1_ready;
  assign op_a     = req1_ready ? req1_a : req0_a;
  assign op_x     = req1_ready ? req1_x : req0_x;

  booth_mult_core #(.N(N)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (op_a),
    .x     (op_x),
    .done  (core_done),
    .p     (core_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_p     <= '0;
      busy      <= 1'b0;
`ifdef MULT_ARB_RR_EN
      ptr       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            rsp_id <= grant_id;
`ifdef MULT_ARB_RR_EN
            ptr    <= ~grant_id;
`endif
          end
        end
        RUN: begin
          if (core_done) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_p     <= core_p;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized, model-checked bench for mult_arbiter (N=8)
module tb_mult_arbiter;

  localparam int N = 8;
`ifdef MULT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [N-1:0]   req0_a = '0, req0_x = '0, req1_a = '0, req1_x = '0;
  logic           rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
  logic [2*N-1:0] rsp_p;

  mult_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_x(req0_x),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_x(req1_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int rsp_cnt = 0, hs_cyc = 0;
  int dut_acc[2] = '{0, 0};
  int g_id[$], g_cyc[$];

  // behavioural model state
  bit             m_active = 0, m_ptr = 0;
  int             m_age = 0, m_id = 0;
  logic [2*N-1:0] m_prod = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] x);
    longint sa, sx;
    sa = longint'($signed(a));
    sx = longint'($signed(x));
    return (2*N)'(sa * sx);
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom % 6)
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      3: return 8'h00;
      default: return N'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // compare process: model predicts readies, busy and response every cycle
  always @(negedge clk) begin
    int  w;
    bit  exp_valid;
    if (rst) begin
      m_active = 0; m_age = 0; m_ptr = 0;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_p", rsp_p, 0);
    end else begin
      if (m_active) m_age++;
      exp_valid = m_active && (m_age >= N + 1);
      w = -1;
      if (!m_active) begin
        if (req0_valid && req1_valid) w = RR ? int'(m_ptr) : 0;
        else if (req0_valid)          w = 0;
        else if (req1_valid)          w = 1;
      end
      chk("req0_ready", req0_ready, w == 0);
      chk("req1_ready", req1_ready, w == 1);
      chk("busy", busy, m_active);
      chk("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        chk("rsp_p", rsp_p, m_prod);
        chk("rsp_id", rsp_id, m_id);
      end
      if (req0_valid && req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); dut_acc[0]++; end
      if (req1_valid && req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); dut_acc[1]++; end
      if (rsp_valid && rsp_ready) begin rsp_cnt++; hs_cyc = cyc; end
      if (exp_valid && rsp_ready) m_active = 0;
      if (w >= 0) begin
        m_active = 1; m_age = 0; m_id = w;
        m_prod = (w == 1) ? prod(req1_a, req1_x) : prod(req0_a, req0_x);
        m_ptr = (w == 0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // one job end to end; operands are scrambled right after acceptance
  task automatic run_job(input int id, input logic [N-1:0] a, input logic [N-1:0] x,
                         input logic [2*N-1:0] exp);
    int t_acc, n;
    bit seen;
    @(posedge clk); #1;
    rsp_ready = 1;
    if (id == 0) begin req0_valid = 1; req0_a = a; req0_x = x; end
    else         begin req1_valid = 1; req1_a = a; req1_x = x; end
    seen = 0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = (id == 0) ? req0_ready : req1_ready;
      n++;
    end
    chk("job_accept", seen, 1);
    t_acc = cyc;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_a = N'($urandom); req0_x = N'($urandom);
    req1_a = N'($urandom); req1_x = N'($urandom);
    seen = 0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = rsp_valid;
      n++;
    end
    chk("job_latency", cyc - t_acc, N + 1);
    chk("job_rsp_p", rsp_p, exp);
    chk("job_rsp_id", rsp_id, id);
  endtask

  initial begin
    int n, rc, s0, s1, g0;
    bit saw;
    @(negedge clk);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_busy", busy, 0);
    #1 rst = 0;

    run_job(0, 8'h07, 8'hFD, 16'hFFEB);
    run_job(0, 8'h80, 8'h80, 16'h4000);
    run_job(1, 8'h80, 8'h7F, 16'hC080);
    run_job(0, 8'h03, 8'h04, 16'h000C);

    // contention
    do_reset();
    g_id.delete(); g_cyc.delete();
    req0_a = 8'h11; req0_x = 8'h02; req1_a = 8'hF0; req1_x = 8'h03;
    req0_valid = 1; req1_valid = 1;
    n = 0;
    while (g_id.size() < 4 && n < 80) begin @(negedge clk); n++; end
    chk("cont_grants", g_id.size() >= 4, 1);
    if (g_id.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        chk("cont_id", g_id[i], RR ? (i % 2) : 0);
      for (int i = 1; i < 4; i++)
        chk("cont_period", g_cyc[i] - g_cyc[i-1], N + 2);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    repeat (15) @(posedge clk);

    // backpressure
    do_reset();
    rsp_ready = 0; req0_valid = 1; req0_a = 8'h05; req0_x = 8'h06;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    @(posedge clk); #1 req0_a = 8'h02; req0_x = 8'h03;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 30);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_p", rsp_p, 16'd30);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1;
    g0 = g_cyc.size();
    n = 0;
    while (g_cyc.size() == g0 && n < 20) begin @(negedge clk); n++; end
    chk("bp_next_accept", (g_cyc.size() > g0) ? g_cyc[g0] - hs_cyc : -1, 1);
    @(posedge clk); #1 req0_valid = 0;
    repeat (15) @(posedge clk);

    // reset mid-run
    @(posedge clk); #1 req0_valid = 1; req0_a = 8'h33; req0_x = 8'h44;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    @(posedge clk); #1 req0_valid = 0;
    rc = rsp_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    saw = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid) saw = 1; end
    chk("mid_rst_no_rsp", saw, 0);
    chk("mid_rst_rsp_cnt", rsp_cnt, rc);
    run_job(1, 8'h09, 8'hF5, 16'hFF9D);

    // randomized traffic
    s0 = dut_acc[0]; s1 = dut_acc[1];
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom % 4) != 0;
      if (req0_valid && dut_acc[0] != s0) begin req0_valid = 0; s0 = dut_acc[0]; end
      if (req1_valid && dut_acc[1] != s1) begin req1_valid = 0; s1 = dut_acc[1]; end
      if (!req0_valid) begin
        req0_a = rand_op(); req0_x = rand_op();
        if ($urandom % 3 == 0) req0_valid = 1;
      end
      if (!req1_valid) begin
        req1_a = rand_op(); req1_x = rand_op();
        if ($urandom % 3 == 0) req1_valid = 1;
      end
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Two-requester arbiter and sequencer for a shared iterative radix-2 Booth multiplier. Accepts signed N×N multiply jobs over valid/ready handshakes. Grants one job at a time and runs the multiplier for N iterations. Returns the 2N-bit product tagged with the requester ID over a valid/ready response channel. Sits between the arithmetic clients and the single multiplier datapath so that the datapath is time-shared rather than duplicated.

## Interface
Parameters:
- N, 32, operand width in bits; also the iteration count. N ≥ 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0's job is accepted this cycle.
- req0_a  in  N  requester 0 multiplicand, two's complement.
- req0_x  in  N  requester 0 multiplier, two's complement.
- req1_valid, req1_ready, req1_a, req1_x: same as the requester 0 ports, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that owns the result.
- rsp_p  out  2N  signed product a·x.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: no job held.
  - RUN: N Booth iterations in progress.
  - DONE: result held.
- IDLE:
  - Arbitrate among asserted reqX_valid.
  - Assert reqX_ready combinationally for the granted requester only.
  - On the handshake, latch the operands and ID, load the core, and go to RUN.
  - With no valid request, stay in IDLE.
- RUN:
  - The core performs one Booth step per cycle. Each step examines the pair {x[i], x[i-1]} with x[-1]=0: add a, subtract a, or add 0, then arithmetic right shift.
  - a is sign-extended to N+1 bits so that the most-negative operands do not overflow.
  - After N steps, go to DONE.
- DONE:
  - Hold rsp_valid=1 with rsp_p and rsp_id stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No job is accepted in the same cycle as the response.
- Requester contract:
  - reqX_valid and the operands must be held until ready.
  - Operand changes after acceptance are ignored.
- Ready rule: reqX_ready is never asserted outside IDLE.
- Arithmetic: rsp_p is the exact signed product. The full 2N bits are used with no truncation, e.g. (-2^(N-1))·(-2^(N-1)) = 2^(2N-2).
- Reset values:
  - FSM returns to IDLE.
  - req0_ready=0, req1_ready=0 (no valid requests during reset), rsp_valid=0, rsp_id=0, rsp_p=0, busy=0.
  - Priority pointer favours requester 0.
- Reset mid-operation: the in-flight job is discarded with no response. The requester is not re-notified.
- While rsp_valid is asserted and the consumer stalls, new requests wait. There is no queueing.

## Timing
- Acceptance: the handshake occurs in IDLE cycle t.
- Iterations: the core runs in cycles t+1 … t+N.
- Response: rsp_valid rises in cycle t+N+1.
- Minimum job-to-job period: N+2 cycles, i.e. the response is accepted in cycle t+N+1 and the next accept happens in cycle t+N+2.
- Consumer stall: a stall of k cycles delays the next accept by k cycles.
- Outputs: rsp_p, rsp_id and busy are registered. The reqX_ready signals are combinational from state, the pointer and the reqX_valid inputs.

## Configuration
- MULT_ARB_RR_EN defined: round-robin arbitration.
  - The priority pointer flips to the other requester after each grant.
  - With both requesters continuously valid, grants alternate 0,1,0,1…
- MULT_ARB_RR_EN undefined: fixed priority.
  - Requester 0 always wins when both are valid.
  - The pointer register is removed.

## Structure
- Package mult_arb_pkg contains:
  - FSM state enum {IDLE, RUN, DONE}.
  - ID width constant (1).
  - Iteration counter width $clog2(N)+1, as a localparam function of N.
- Sub-module booth_mult_core:
  - Ports: clk, rst, start, a, x, done, p.
  - On start it loads the operands and runs exactly N iterations, pulsing done when finished.
  - The arbiter owns the handshakes, the FSM and the response register.

## Test plan
All scenarios use N=8.
- Single job: req0 with a=7, x=-3 → req0_ready in the accept cycle; rsp_valid exactly 9 cycles later; rsp_p=-21 (0xFFEB), rsp_id=0.
- Corner operands: a=-128, x=-128 → rsp_p=0x4000. Also a=-128, x=127 → rsp_p=-16256.
- Contention: both requesters continuously valid with rsp_ready=1.
  - With MULT_ARB_RR_EN, grants alternate 0,1,0,1, one accept every 10 cycles.
  - Without MULT_ARB_RR_EN, only requester 0 is granted.
- Backpressure: rsp_ready held low for 5 cycles in DONE → rsp_p and rsp_id stay stable; both reqX_ready stay 0; the next accept occurs the cycle after the response handshake.
- Reset mid-run: assert rst 4 cycles after accept → the FSM is back in IDLE with rsp_valid=0 and busy=0, and no response is ever issued. The next req1 job completes correctly.
- Operand hold: change req0_a after acceptance → the result reflects the latched operands.
